// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit.
// Holds the sequencer state enum, the 16 opcode constants, the ALU operation
// codes and the packed bundle of opcode-static datapath selects.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_ORI  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_JAL  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;

  // Selects that depend only on the opcode, held for DECODE..WRITEBACK.
  typedef struct packed {
    logic       M1;
    logic       M3;
    logic       M4;
    logic       M5;
    logic       M6;
    logic       M7;
    logic [3:0] alu;
  } sel_t;

  // Every opcode from ADD through LW writes a result, plus JAL (link).
  function automatic logic writes_rf(input logic [3:0] op);
    return (op <= OP_LW) || (op == OP_JAL);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the CPU control unit and the datapath.
// master: control unit (takes opcode/Eq, drives state, strobes and selects).
// slave: datapath view of the same signals.
interface cpu_control_fsm_if;
  import cpu_ctrl_pkg::*;

  logic [3:0] opcode;
  logic       Eq;
  state_t     state;
  logic       instruction_flag;
  logic       change_address_flag;
  logic       pc_flag;
  logic       M1;
  logic       M2;
  logic       M3;
  logic       M4;
  logic       M5;
  logic       M6;
  logic       M7;
  logic [3:0] ALU;
  logic       Wr_en;
  logic       Wr_en_rf;

  modport master (
    input  opcode, Eq,
    output state, instruction_flag, change_address_flag, pc_flag,
           M1, M2, M3, M4, M5, M6, M7, ALU, Wr_en, Wr_en_rf
  );

  modport slave (
    output opcode, Eq,
    input  state, instruction_flag, change_address_flag, pc_flag,
           M1, M2, M3, M4, M5, M6, M7, ALU, Wr_en, Wr_en_rf
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Opcode decoder: maps the 4-bit opcode to the static datapath selects and ALU code.
// Ports: opcode in (4), sel out (sel_t). Purely combinational, no state.
// Selects not used by an opcode, and the ALU code of non-ALU opcodes, are 0.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output sel_t       sel
);

  always_comb begin
    sel = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLL: begin
        sel.M4 = 1'b1;
        sel.M5 = 1'b1;
        sel.M7 = 1'b1;
        case (opcode)
          OP_SUB:  sel.alu = ALU_SUB;
          OP_AND:  sel.alu = ALU_AND;
          OP_OR:   sel.alu = ALU_OR;
          OP_XOR:  sel.alu = ALU_XOR;
          OP_NOR:  sel.alu = ALU_NOR;
          OP_SLT:  sel.alu = ALU_SLT;
          OP_SLL:  sel.alu = ALU_SLL;
          default: sel.alu = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_ORI: begin
        sel.M4  = 1'b1;
        sel.M5  = 1'b1;
        sel.M6  = 1'b1;
        sel.M7  = 1'b1;
        sel.alu = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      // LW/SW route Rb to the memory address; LW also picks memory data as result.
      OP_LW, OP_SW: begin
        sel.M4 = 1'b0;
        sel.M7 = 1'b0;
      end
      OP_JR: begin
        sel.M1 = 1'b1;
      end
      OP_JAL: begin
        sel.M1 = 1'b1;
        sel.M3 = 1'b1;
      end
      default: begin
        // BEQ/BNE: only M2, which is resolved against Eq in WRITEBACK.
        sel = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: 4-state FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
// Ports: clk, rst (async, active-low), bus (master modport: opcode/Eq in, state,
// strobes, mux selects, ALU code and write enables out, all combinational).
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  cpu_control_fsm_if.master     bus
);

  state_t cur_state;
  sel_t   sel;

  cpu_ctrl_decode u_decode (
    .opcode (bus.opcode),
    .sel    (sel)
  );

  // Sequencer advances unconditionally; every instruction takes four cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= FETCH;
    end else begin
      case (cur_state)
        FETCH:     cur_state <= DECODE;
        DECODE:    cur_state <= EXECUTE;
        EXECUTE:   cur_state <= WRITEBACK;
        default:   cur_state <= FETCH;
      endcase
    end
  end

  // Outputs are gated by rst so that asserting reset clears every strobe in
  // the same cycle, including a SW write already in EXECUTE.
  always_comb begin
    bus.state               = FETCH;
    bus.instruction_flag    = 1'b0;
    bus.change_address_flag = 1'b0;
    bus.pc_flag             = 1'b0;
    bus.M1                  = 1'b0;
    bus.M2                  = 1'b0;
    bus.M3                  = 1'b0;
    bus.M4                  = 1'b0;
    bus.M5                  = 1'b0;
    bus.M6                  = 1'b0;
    bus.M7                  = 1'b0;
    bus.ALU                 = 4'd0;
    bus.Wr_en               = 1'b0;
    bus.Wr_en_rf            = 1'b0;
    if (rst) begin
      bus.state = cur_state;
      // FETCH is opcode-independent: the opcode input is stale until the
      // new instruction is latched at the end of this cycle.
      if (cur_state != FETCH) begin
        bus.M1  = sel.M1;
        bus.M3  = sel.M3;
        bus.M4  = sel.M4;
        bus.M5  = sel.M5;
        bus.M6  = sel.M6;
        bus.M7  = sel.M7;
        bus.ALU = sel.alu;
      end
      case (cur_state)
        FETCH: begin
          bus.instruction_flag = 1'b1;
        end
        DECODE: begin
          bus.change_address_flag = is_mem(bus.opcode);
        end
        EXECUTE: begin
          bus.Wr_en = (bus.opcode == OP_SW);
        end
        default: begin
          bus.pc_flag  = 1'b1;
          bus.Wr_en_rf = writes_rf(bus.opcode);
          bus.M2       = ((bus.opcode == OP_BEQ) &&  bus.Eq) ||
                         ((bus.opcode == OP_BNE) && !bus.Eq);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed and random opcode/Eq
// stimulus compared every cycle against a table-style reference model.
module tb_cpu_control_fsm;

  logic clk;
  logic rst;
  int   phase;
  int   n_checks;
  int   n_pass;

  cpu_control_fsm_if bus ();

  cpu_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] state;
    logic       iflag;
    logic       caf;
    logic       pcf;
    logic       m1;
    logic       m2;
    logic       m3;
    logic       m4;
    logic       m5;
    logic       m6;
    logic       m7;
    logic [3:0] alu;
    logic       wr_en;
    logic       wr_en_rf;
  } exp_t;

  // Reference: phase is the cycle index within the instruction, counted by the bench.
  function automatic exp_t model(input int ph, input logic [3:0] op, input logic eq,
                                 input logic rv);
    exp_t e;
    int   o;
    bit   rtype, immop, lw, sw, beq, bne, jr, jal;
    e = '0;
    if (!rv) return e;
    e.state = 2'(ph);
    if (ph == 0) begin
      e.iflag = 1'b1;
      return e;
    end
    o     = int'(op);
    rtype = (o <= 7);
    immop = (o == 8) || (o == 9);
    lw    = (o == 10);
    sw    = (o == 11);
    beq   = (o == 12);
    bne   = (o == 13);
    jr    = (o == 14);
    jal   = (o == 15);
    e.alu = rtype ? op : ((o == 9) ? 4'd3 : 4'd0);
    e.m1  = jr || jal;
    e.m3  = jal;
    e.m4  = rtype || immop;
    e.m5  = rtype || immop;
    e.m6  = immop;
    e.m7  = rtype || immop;
    if (ph == 1) e.caf = lw || sw;
    if (ph == 2) e.wr_en = sw;
    if (ph == 3) begin
      e.pcf      = 1'b1;
      e.wr_en_rf = (o <= 10) || jal;
      e.m2       = (beq && eq) || (bne && !eq);
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t a;
    a.state    = 2'(bus.state);
    a.iflag    = bus.instruction_flag;
    a.caf      = bus.change_address_flag;
    a.pcf      = bus.pc_flag;
    a.m1       = bus.M1;
    a.m2       = bus.M2;
    a.m3       = bus.M3;
    a.m4       = bus.M4;
    a.m5       = bus.M5;
    a.m6       = bus.M6;
    a.m7       = bus.M7;
    a.alu      = bus.ALU;
    a.wr_en    = bus.Wr_en;
    a.wr_en_rf = bus.Wr_en_rf;
    return a;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    exp_t a;
    e = model(phase, bus.opcode, bus.Eq, rst);
    a = observe();
    n_checks++;
    assert (a === e) n_pass++;
    else $error("FAIL %s: phase %0d op %h eq %b observed %h expected %h",
                tag, phase, bus.opcode, bus.Eq, a, e);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic req);
    n_checks++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, req);
  endtask

  // One clock: advance the model, drive new inputs mid-cycle, then compare.
  task automatic step(input logic [3:0] op, input logic eq, input string tag);
    @(posedge clk);
    if (rst) phase = (phase + 1) % 4;
    else     phase = 0;
    #2;
    bus.opcode = op;
    bus.Eq     = eq;
    #1;
    check(tag);
  endtask

  // Starting from a FETCH cycle: covers DECODE, EXECUTE, WRITEBACK, next FETCH.
  task automatic run_instr(input logic [3:0] op, input logic eq, input string tag);
    for (int k = 0; k < 4; k++) step(op, eq, tag);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    phase      = 0;
    rst        = 1'b0;
    bus.opcode = 4'hB;
    bus.Eq     = 1'b1;
    #3;
    check("reset_async");
    for (int i = 0; i < 2; i++) step(4'($urandom), 1'($urandom), "reset_hold");

    #2;
    rst = 1'b1;
    #1;
    check("release_fetch");
    for (int i = 0; i < 8; i++) step(4'($urandom), 1'($urandom), "sequence");

    run_instr(4'h0, 1'b0, "add");
    run_instr(4'h8, 1'b1, "addi");
    run_instr(4'h9, 1'b0, "ori");
    run_instr(4'hB, 1'b0, "sw");
    run_instr(4'hA, 1'b1, "lw");
    run_instr(4'hC, 1'b1, "beq_taken");
    run_instr(4'hC, 1'b0, "beq_not_taken");
    run_instr(4'hD, 1'b1, "bne_not_taken");
    run_instr(4'hD, 1'b0, "bne_taken");
    run_instr(4'hE, 1'b0, "jr");
    run_instr(4'hF, 1'b1, "jal");
    run_instr(4'h6, 1'b0, "slt");

    // Inputs re-randomised every cycle, including within FETCH.
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 4; k++) step(4'($urandom), 1'($urandom), "random");
    end

    // Reset in the middle of the EXECUTE cycle of a SW.
    step(4'hB, 1'b0, "sw_rst_decode");
    step(4'hB, 1'b0, "sw_rst_execute");
    check_bit("sw_wr_en_before_rst", bus.Wr_en, 1'b1);
    #2;
    rst   = 1'b0;
    phase = 0;
    #1;
    check("rst_mid_execute");
    check_bit("rst_mid_wr_en", bus.Wr_en, 1'b0);
    step(4'hB, 1'b0, "rst_mid_hold");
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_release_fetch");
    step(4'hB, 1'b0, "rst_mid_next_decode");
    step(4'hB, 1'b0, "rst_mid_next_execute");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
